// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: state encoding, key/event widths,
// key-code mapping and a lowest-set-bit priority pick.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2
    } state_e;

    // Widest row vector the priority pick has to handle.
    localparam int unsigned MAX_LINES = 8;

    // Bits needed for a key code of an rows x cols matrix.
    function automatic int unsigned key_width(input int unsigned rows, input int unsigned cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

    // Event payload: release flag on top of the key code.
    function automatic int unsigned event_width(input int unsigned rows, input int unsigned cols);
        return key_width(rows, cols) + 1;
    endfunction

    // Column-major key numbering.
    function automatic int unsigned key_code(input int unsigned col, input int unsigned row,
                                             input int unsigned rows);
        return col * rows + row;
    endfunction

    // Index of the lowest set bit, 0 when none is set.
    function automatic logic [2:0] lowest_set(input logic [MAX_LINES-1:0] v);
        lowest_set = 3'd0;
        for (int i = MAX_LINES - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event stream from the scanner to the consumer, plus the sticky overflow flag.
interface keypad_scanner_if #(
    parameter int unsigned KEY_W = 4
);
    logic             ev_valid;
    logic             ev_ready;
    logic             ev_release;
    logic [KEY_W-1:0] ev_code;
    logic             overflow;
    logic             clear_ovf;

    modport master (
        output ev_valid, ev_release, ev_code, overflow,
        input  ev_ready, clear_ovf
    );

    modport slave (
        input  ev_valid, ev_release, ev_code, overflow,
        output ev_ready, clear_ovf
    );
endinterface

// File: rtl/key_event_fifo.sv
// Small event FIFO with a registered head output and a sticky overflow flag.
// Head registers are loaded from the next-cycle head so a pop never re-presents a stale entry.
module key_event_fifo #(
    parameter int unsigned W     = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    input  logic         clear_ovf_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         overflow_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  data_q;
    logic          ovf_q;
    logic          empty_c, full_c, pop_c, wr_en_c, drop_c;
    logic [W-1:0]  head_c;

    // Pointer arithmetic, accept/drop decisions and next head entry.
    always_comb begin
        empty_c = (rd_q == wr_q);
        full_c  = (rd_q[AW-1:0] == wr_q[AW-1:0]) && (rd_q[AW] != wr_q[AW]);
        pop_c   = pop_i && !empty_c;
        wr_en_c = push_i && (!full_c || pop_c);
        drop_c  = push_i && full_c && !pop_c;
        rd_d    = rd_q + PW'(pop_c);
        wr_d    = wr_q + PW'(wr_en_c);
        valid_d = (rd_d != wr_d);
        // The entry being written this cycle becomes head when it lands on the next read slot.
        if (wr_en_c && (wr_q[AW-1:0] == rd_d[AW-1:0])) begin
            head_c = push_data_i;
        end else begin
            head_c = mem_q[rd_d[AW-1:0]];
        end
    end

    // Storage array; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (wr_en_c) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end

    // Pointers, head output and overflow flag (a drop beats a clear).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            valid_q <= valid_d;
            if (valid_d) data_q <= head_c;
            if (drop_c) begin
                ovf_q <= 1'b1;
            end else if (clear_ovf_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign overflow_o = ovf_q;
endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-cold column drive stepped by a prescaler tick, synchronised
// active-low rows, single-key press/release debouncing and an event FIFO toward the consumer.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS           = 3,
    parameter int unsigned COLS           = 3,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 6,
    parameter int unsigned REPORT_RELEASE = 1,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] column,
    keypad_scanner_if.master ev
);
    localparam int unsigned KEY_W = key_width(ROWS, COLS);
    localparam int unsigned EV_W  = event_width(ROWS, COLS);
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [PRE_W-1:0] presc_q;
    logic [ROWS-1:0]  row_meta_q, row_sync_q;
    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [COLS-1:0]  column_q;

    logic             tick_c;
    logic [ROWS-1:0]  row_low_c;
    logic [ROW_W-1:0] cand_new_c;
    logic [COL_W-1:0] col_next_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             push_c, push_rel_c;
    logic [KEY_W-1:0] push_code_c;
    logic [EV_W-1:0]  head_w;

    // Prescaler and two-flop row synchroniser (idle rows read high).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            presc_q    <= tick_c ? '0 : presc_q + PRE_W'(1);
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // Scan / debounce next-state logic; everything moves only on a tick.
    always_comb begin
        tick_c      = (presc_q == PRE_W'(SCAN_DIV - 1));
        row_low_c   = ~row_sync_q;
        cand_new_c  = ROW_W'(lowest_set(MAX_LINES'(row_low_c)));
        col_next_c  = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
        cnt_inc_c   = cnt_q + CNT_W'(1);
        state_d     = state_q;
        col_d       = col_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        push_c      = 1'b0;
        push_rel_c  = 1'b0;
        push_code_c = KEY_W'(key_code(32'(col_q), 32'(cand_q), ROWS));
        if (tick_c) begin
            case (state_q)
                SCAN: begin
                    if (|row_low_c) begin
                        cand_d      = cand_new_c;
                        push_code_c = KEY_W'(key_code(32'(col_q), 32'(cand_new_c), ROWS));
                        if (DEBOUNCE_TICKS == 1) begin
                            push_c  = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = DEB_PRESS;
                        end
                    end else begin
                        col_d = col_next_c;
                    end
                end
                DEB_PRESS: begin
                    if (!row_low_c[cand_q]) begin
                        cnt_d   = '0;
                        col_d   = col_next_c;
                        state_d = SCAN;
                    end else if (cnt_inc_c == CNT_W'(DEBOUNCE_TICKS)) begin
                        push_c  = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                HELD: begin
                    if (row_low_c[cand_q]) begin
                        cnt_d = '0;
                    end else if (cnt_inc_c == CNT_W'(DEBOUNCE_TICKS)) begin
                        push_c     = (REPORT_RELEASE != 0);
                        push_rel_c = 1'b1;
                        cnt_d      = '0;
                        col_d      = col_next_c;
                        state_d    = SCAN;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            endcase
        end
    end

    // FSM registers and registered one-cold column drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SCAN;
            col_q    <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            column_q <= ~COLS'(1);
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            column_q <= ~(COLS'(1) << col_d);
        end
    end

    key_event_fifo #(
        .W     (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_c),
        .push_data_i ({push_rel_c, push_code_c}),
        .pop_i       (ev.ev_ready),
        .clear_ovf_i (ev.clear_ovf),
        .valid_o     (ev.ev_valid),
        .data_o      (head_w),
        .overflow_o  (ev.overflow)
    );

    assign column        = column_q;
    assign ev.ev_release = head_w[EV_W-1];
    assign ev.ev_code    = head_w[KEY_W-1:0];
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: 3x3 keypad, SCAN_DIV=4, DEBOUNCE_TICKS=3, depth-4 FIFO.
// Instance a reports releases, instance b does not. Each keypad is modelled as a switch matrix.
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int unsigned KW = key_width(3, 3);

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] row_a, row_b, column_a, column_b;
    logic [8:0] keys_a, keys_b;
    int         n_vec = 0;
    int         n_err = 0;
    int         n;
    int unsigned codes_b [5] = '{0, 4, 8, 1, 5};

    always #5 clk = ~clk;

    keypad_scanner_if #(.KEY_W(KW)) ev_a ();
    keypad_scanner_if #(.KEY_W(KW)) ev_b ();

    keypad_scanner #(
        .ROWS(3), .COLS(3), .SCAN_DIV(4), .DEBOUNCE_TICKS(3), .REPORT_RELEASE(1), .FIFO_DEPTH(4)
    ) u_dut_a (
        .clk(clk), .reset(reset), .row(row_a), .column(column_a), .ev(ev_a.master)
    );

    keypad_scanner #(
        .ROWS(3), .COLS(3), .SCAN_DIV(4), .DEBOUNCE_TICKS(3), .REPORT_RELEASE(0), .FIFO_DEPTH(4)
    ) u_dut_b (
        .clk(clk), .reset(reset), .row(row_b), .column(column_b), .ev(ev_b.master)
    );

    // Switch matrix: a closed key pulls its row low while its column is driven low.
    always_comb begin
        row_a = '1;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (keys_a[c*3+r] && !column_a[c]) row_a[r] = 1'b0;
            end
        end
    end

    always_comb begin
        row_b = '1;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (keys_b[c*3+r] && !column_b[c]) row_b[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_col_a(input logic [2:0] val, input int budget, output int waited);
        waited = 0;
        while (column_a !== val && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic wait_valid_a(input int budget);
        int w = 0;
        while (ev_a.ev_valid !== 1'b1 && w < budget) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic pop_a();
        ev_a.ev_ready = 1'b1;
        @(negedge clk);
        ev_a.ev_ready = 1'b0;
    endtask

    task automatic pop_b();
        ev_b.ev_ready = 1'b1;
        @(negedge clk);
        ev_b.ev_ready = 1'b0;
    endtask

    initial begin
        keys_a         = '0;
        keys_b         = '0;
        ev_a.ev_ready  = 1'b0;
        ev_a.clear_ovf = 1'b0;
        ev_b.ev_ready  = 1'b0;
        ev_b.clear_ovf = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_column", 32'(column_a), 32'(3'b110));
        check("rst_valid", 32'(ev_a.ev_valid), 32'd0);
        check("rst_release", 32'(ev_a.ev_release), 32'd0);
        check("rst_code", 32'(ev_a.ev_code), 32'd0);
        check("rst_overflow", 32'(ev_a.overflow), 32'd0);
        reset = 1'b0;

        // 1: idle scanning, one column step every 4 clocks
        wait_col_a(3'b101, 20, n);
        check("t1_col1", 32'(column_a), 32'(3'b101));
        wait_col_a(3'b011, 20, n);
        check("t1_col2", 32'(column_a), 32'(3'b011));
        check("t1_step12", 32'(n), 32'd4);
        wait_col_a(3'b110, 20, n);
        check("t1_col0", 32'(column_a), 32'(3'b110));
        check("t1_step20", 32'(n), 32'd4);
        wait_col_a(3'b101, 20, n);
        check("t1_step01", 32'(n), 32'd4);
        check("t1_idle_valid", 32'(ev_a.ev_valid), 32'd0);

        // 2: key at col2/row1 -> press then release of code 7
        keys_a[7] = 1'b1;
        wait_valid_a(200);
        check("t2_press_valid", 32'(ev_a.ev_valid), 32'd1);
        check("t2_press_rel", 32'(ev_a.ev_release), 32'd0);
        check("t2_press_code", 32'(ev_a.ev_code), 32'd7);
        pop_a();
        check("t2_single_press", 32'(ev_a.ev_valid), 32'd0);
        keys_a[7] = 1'b0;
        wait_valid_a(200);
        check("t2_rel_valid", 32'(ev_a.ev_valid), 32'd1);
        check("t2_rel_rel", 32'(ev_a.ev_release), 32'd1);
        check("t2_rel_code", 32'(ev_a.ev_code), 32'd7);
        pop_a();
        check("t2_drained", 32'(ev_a.ev_valid), 32'd0);

        // 3: row0 low for two ticks on col0 -> no event, scan resumes at col1
        wait_col_a(3'b101, 20, n);
        wait_col_a(3'b110, 20, n);
        keys_a[0] = 1'b1;
        repeat (7) @(negedge clk);
        keys_a[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_resume_col1", 32'(column_a), 32'(3'b101));
        check("t3_no_event", 32'(ev_a.ev_valid), 32'd0);

        // 4: rows 0 and 2 together on col1 -> code 3; one-tick bounce gives no release
        keys_a[3] = 1'b1;
        keys_a[5] = 1'b1;
        wait_valid_a(200);
        check("t4_press_valid", 32'(ev_a.ev_valid), 32'd1);
        check("t4_press_code", 32'(ev_a.ev_code), 32'd3);
        check("t4_press_rel", 32'(ev_a.ev_release), 32'd0);
        pop_a();
        check("t4_one_event", 32'(ev_a.ev_valid), 32'd0);
        keys_a[3] = 1'b0;
        keys_a[5] = 1'b0;
        repeat (4) @(negedge clk);
        keys_a[3] = 1'b1;
        keys_a[5] = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_bounce_no_rel", 32'(ev_a.ev_valid), 32'd0);
        check("t4_still_held", 32'(column_a), 32'(3'b101));
        keys_a[3] = 1'b0;
        keys_a[5] = 1'b0;
        wait_valid_a(200);
        check("t4_rel_rel", 32'(ev_a.ev_release), 32'd1);
        check("t4_rel_code", 32'(ev_a.ev_code), 32'd3);
        pop_a();

        // 5: press-only instance, five presses into a depth-4 FIFO with no consumer
        for (int i = 0; i < 5; i++) begin
            keys_b[codes_b[i]] = 1'b1;
            repeat (48) @(negedge clk);
            keys_b = '0;
            repeat (48) @(negedge clk);
            if (i == 3) check("t5_full_no_ovf", 32'(ev_b.overflow), 32'd0);
        end
        check("t5_overflow", 32'(ev_b.overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t5_drain_valid", 32'(ev_b.ev_valid), 32'd1);
            check("t5_drain_code", 32'(ev_b.ev_code), codes_b[i]);
            check("t5_drain_rel", 32'(ev_b.ev_release), 32'd0);
            pop_b();
        end
        check("t5_empty", 32'(ev_b.ev_valid), 32'd0);
        check("t5_ovf_held", 32'(ev_b.overflow), 32'd1);
        ev_b.clear_ovf = 1'b1;
        @(negedge clk);
        ev_b.clear_ovf = 1'b0;
        check("t5_ovf_cleared", 32'(ev_b.overflow), 32'd0);

        // 6: reset during DEB_PRESS with two events queued
        keys_a[2] = 1'b1;
        repeat (48) @(negedge clk);
        keys_a[2] = 1'b0;
        repeat (48) @(negedge clk);
        check("t6_queued_head", 32'(ev_a.ev_code), 32'd2);
        check("t6_queued_valid", 32'(ev_a.ev_valid), 32'd1);
        wait_col_a(3'b110, 20, n);
        wait_col_a(3'b011, 20, n);
        keys_a[6] = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_in_debounce", 32'(column_a), 32'(3'b011));
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(ev_a.ev_valid), 32'd0);
        check("t6_rst_ovf", 32'(ev_a.overflow), 32'd0);
        check("t6_rst_column", 32'(column_a), 32'(3'b110));
        keys_a[6] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("t6_no_stale", 32'(ev_a.ev_valid), 32'd0);
        keys_a[4] = 1'b1;
        wait_valid_a(200);
        check("t6_fresh_code", 32'(ev_a.ev_code), 32'd4);
        check("t6_fresh_rel", 32'(ev_a.ev_release), 32'd0);
        keys_a[4] = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Parametrised matrix-keypad scanner for an R×C keypad with active-low rows and columns. It replaces divided-clock scanning with a single-clock design driven by clock-enable ticks. It adds per-press and optional per-release debouncing, press/release events, and a small event FIFO with a valid/ready output. It sits between the keypad pins and the game controller, which consumes key events.

Parameters:
ROWS, 3, number of row inputs (2..8)
COLS, 3, number of column outputs (2..8)
SCAN_DIV, 50000, clk cycles per scan tick (≥2); internal prescaler
DEBOUNCE_TICKS, 6, consecutive stable ticks required to accept a press or release (≥1)
REPORT_RELEASE, 1, 1 = emit release events as well as press events
FIFO_DEPTH, 4, event FIFO entries (power of 2, ≥2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
row  in  ROWS  raw keypad rows; low = key closed on the driven column
column  out  COLS  one-cold column drive; low = column driven
ev_valid  out  1  FIFO head event available
ev_ready  in  1  consumer accepts head event this cycle
ev_release  out  1  head event type: 0 = press, 1 = release
ev_code  out  KEY_W  head key code = col*ROWS + row; KEY_W = clog2(ROWS*COLS)
overflow  out  1  sticky: an event was dropped because the FIFO was full
clear_ovf  in  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync release): prescaler=0, state=SCAN, col_idx=0, column = all ones except bit0=0, debounce count=0, FIFO empty, ev_valid=0, ev_release=0, ev_code=0, overflow=0.
- row passes through a 2-flop synchroniser; all decisions use the synchronised value (2-cycle latency).
- Tick: one-cycle pulse when the prescaler wraps at SCAN_DIV-1. All FSM transitions occur only on tick cycles.
- column always drives ~(1<<col_idx). col_idx wraps COLS-1 → 0.
- SCAN, on tick:
  - If any synchronised row is low: latch cand_row = lowest-index low row, count=1, go to DEB_PRESS. col_idx is held.
  - Else advance col_idx.
- DEB_PRESS, on tick:
  - If row[cand_row] is low: count++. When count reaches DEBOUNCE_TICKS, push {0, code} and go to HELD with count=0.
  - If row[cand_row] is high: go to SCAN and advance col_idx. No event is emitted.
  - With DEBOUNCE_TICKS=1, the event is pushed on the entry tick itself.
- HELD, on tick:
  - If row[cand_row] is high: count++. When count reaches DEBOUNCE_TICKS, push {1, code} if REPORT_RELEASE, then go to SCAN and advance col_idx.
  - If row[cand_row] is low: count=0 (bounce).
- Other keys pressed while in DEB_PRESS or HELD are ignored. Only one key is tracked at a time, and there is no ghost detection.
- FIFO:
  - Push and pop in the same cycle are always accepted, including when full.
  - Push when full with no pop: event dropped, overflow=1.
  - Pop occurs when ev_valid && ev_ready. ev_ready while empty has no effect.
  - ev_* are registered outputs from the head entry. First-word latency is 1 clk after push.
- overflow: clear_ovf clears it. If clear_ovf and a drop occur in the same cycle, set wins.
- Reset mid-operation discards pending debounce state and all FIFO contents.
- Counter widths:
  - prescaler: clog2(SCAN_DIV)
  - debounce count: clog2(DEBOUNCE_TICKS+1)
  - FIFO pointers: clog2(FIFO_DEPTH)+1, wrap by natural overflow.

Decomposition:
- Package keypad_pkg holds:
  - state encoding: SCAN, DEB_PRESS, HELD
  - KEY_W and the event-width function
  - key-code function col*ROWS+row
  - the lowest-set-bit priority function
- Sub-module key_event_fifo (parametrised width/depth, push/pop/full/empty/drop) is a natural split. The FSM, prescaler and synchroniser stay in keypad_scanner.

Test Plan:
(ROWS=3, COLS=3, SCAN_DIV=4, DEBOUNCE_TICKS=3, FIFO_DEPTH=4, REPORT_RELEASE=1 unless noted.)
1. Idle rows all high → column cycles 110,101,011 with a period of 12 clks; ev_valid stays 0.
2. Hold row1 low only while col2 is driven, stable ≥3 ticks → one event: ev_release=0, ev_code=7. Release → event release=1, code=7.
3. row0 low for 2 ticks on col0, then high → no event; scanning resumes at col1.
4. Rows 0 and 2 low together on col1 → press code 3 only. A bounce high for 1 tick in HELD produces no release.
5. ev_ready=0; five distinct press/release-filtered presses (REPORT_RELEASE=0) → 4 events held, overflow=1. Drain → codes in order. clear_ovf → overflow=0.
6. Assert reset during DEB_PRESS with 2 events queued → same cycle: ev_valid=0, overflow=0, column=110. No stale event appears after release.
